// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multi-channel PWM generator.
package pwm_pkg;

  localparam int PWM_WIDTH      = 16;
  localparam int PWM_CHANNELS   = 4;
  localparam int PWM_PRESCALE_W = 8;

  typedef enum logic {PWM_EDGE, PWM_CENTER} pwm_mode_t;

  // Counter direction; edge-aligned mode only ever counts up.
  typedef enum logic {DIR_UP, DIR_DOWN} pwm_dir_t;

endpackage

// File: rtl/pwm_multi_channel_if.sv
// Configuration bus into the PWM block: shadow values, update strobe and pending status.
interface pwm_multi_channel_if
  import pwm_pkg::*;
#(
  parameter int WIDTH    = PWM_WIDTH,
  parameter int CHANNELS = PWM_CHANNELS
);

  logic [WIDTH-1:0]          period;
  logic [CHANNELS*WIDTH-1:0] duty;
  logic [CHANNELS-1:0]       polarity;
  logic                      center_mode;
  logic                      update;
  logic                      update_pending;

  modport master (
    output period, duty, polarity, center_mode, update,
    input  update_pending
  );

  modport slave (
    input  period, duty, polarity, center_mode, update,
    output update_pending
  );

endinterface

// File: rtl/pwm_channel.sv
// One PWM output: compare shared count against this channel's duty, apply polarity, register.
module pwm_channel #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] count,
  input  logic [WIDTH-1:0] duty,
  input  logic             polarity,
  output logic             pwm_out
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out <= 1'b0;
    end else if (!enable) begin
      pwm_out <= polarity;
    end else begin
      pwm_out <= (count < duty) ^ polarity;
    end
  end

endmodule

// File: rtl/pwm_multi_channel.sv
// N-channel PWM with a shared prescaled counter, edge/center alignment and
// double-buffered period/duty/polarity/mode that switch over only at a period boundary.
module pwm_multi_channel
  import pwm_pkg::*;
#(
  parameter int WIDTH      = PWM_WIDTH,
  parameter int CHANNELS   = PWM_CHANNELS,
  parameter int PRESCALE_W = PWM_PRESCALE_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  pwm_multi_channel_if.slave    cfg,
  output logic                  period_tick,
  output logic [CHANNELS-1:0]   pwm_out
);

  logic [PRESCALE_W-1:0]     pre_cnt;
  logic                      tick;
  logic                      boundary;

  logic [WIDTH-1:0]          count, count_nxt;
  pwm_dir_t                  dir, dir_nxt;

  logic [WIDTH-1:0]          sh_period, act_period;
  logic [CHANNELS*WIDTH-1:0] sh_duty, act_duty;
  logic [CHANNELS-1:0]       sh_pol, act_pol;
  pwm_mode_t                 sh_mode, act_mode;
  logic                      pending;

  // >= rather than == so a live prescale shrinking below pre_cnt cannot stall the counter.
  assign tick     = enable && (pre_cnt >= prescale);
  assign boundary = tick && (count_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
    end else if (!enable || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  // Next count/direction assuming a tick happens this cycle.
  always_comb begin
    // NOTE: defaults first so every path assigns every output; no latch can be inferred.
    count_nxt = count;
    dir_nxt   = dir;
    if (act_mode == PWM_EDGE) begin
      count_nxt = (count >= act_period) ? '0 : count + 1'b1;
      dir_nxt   = DIR_UP;
    end else begin
      case (dir)
        DIR_UP: begin
          if (count < act_period) begin
            count_nxt = count + 1'b1;
          end else if (act_period != '0) begin
            count_nxt = count - 1'b1;
            dir_nxt   = DIR_DOWN;
          end else begin
            count_nxt = '0;
          end
        end
        DIR_DOWN: count_nxt = count - 1'b1;
        default:  count_nxt = '0;
      endcase
      // Reaching zero always turns the counter back up (also covers P=1).
      if (count_nxt == '0) dir_nxt = DIR_UP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      dir   <= DIR_UP;
    end else if (!enable) begin
      count <= '0;
      dir   <= DIR_UP;
    end else if (tick) begin
      count <= count_nxt;
      dir   <= dir_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      period_tick <= 1'b0;
    end else begin
      period_tick <= boundary;
    end
  end

  // Shadow captures on every strobe; active follows shadow while idle or at a pending boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_period  <= '0;
      sh_duty    <= '0;
      sh_pol     <= '0;
      sh_mode    <= PWM_EDGE;
      act_period <= '0;
      act_duty   <= '0;
      act_pol    <= '0;
      act_mode   <= PWM_EDGE;
      pending    <= 1'b0;
    end else begin
      if (cfg.update) begin
        sh_period <= cfg.period;
        sh_duty   <= cfg.duty;
        sh_pol    <= cfg.polarity;
        sh_mode   <= pwm_mode_t'(cfg.center_mode);
      end
      if (!enable || (boundary && pending)) begin
        act_period <= sh_period;
        act_duty   <= sh_duty;
        act_pol    <= sh_pol;
        act_mode   <= sh_mode;
      end
      if (!enable) begin
        pending <= 1'b0;
      end else if (cfg.update) begin
        pending <= 1'b1;
      end else if (boundary) begin
        pending <= 1'b0;
      end
    end
  end

  assign cfg.update_pending = pending;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pwm_channel #(.WIDTH(WIDTH)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .enable   (enable),
      .count    (count),
      .duty     (act_duty[i*WIDTH +: WIDTH]),
      .polarity (act_pol[i]),
      .pwm_out  (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Self-checking bench: a cycle model predicts outputs into a scoreboard queue; scenario tasks add pattern checks.
module tb_pwm_multi_channel;
  import pwm_pkg::*;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int PW = 8;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic [PW-1:0] prescale;
  logic          period_tick;
  logic [CH-1:0] pwm_out;

  pwm_multi_channel_if #(.WIDTH(W), .CHANNELS(CH)) bus ();

  pwm_multi_channel #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(PW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .prescale    (prescale),
    .cfg         (bus),
    .period_tick (period_tick),
    .pwm_out     (pwm_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] out;
    logic          tick;
    logic          pend;
  } exp_t;

  exp_t sbq[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hi_cnt[CH];
  int   tick_cnt;

  // Reference model state (post-edge values).
  logic [PW-1:0]   m_pre;
  logic [W-1:0]    m_cnt;
  logic            m_up;
  logic [W-1:0]    m_sh_p,   m_act_p;
  logic [CH*W-1:0] m_sh_d,   m_act_d;
  logic [CH-1:0]   m_sh_pol, m_act_pol;
  logic            m_sh_cm,  m_act_cm;
  logic            m_pend,   m_tick;
  logic [CH-1:0]   m_out;

  task automatic model_reset();
    m_pre = '0; m_cnt = '0; m_up = 1'b1;
    m_sh_p = '0; m_act_p = '0; m_sh_d = '0; m_act_d = '0;
    m_sh_pol = '0; m_act_pol = '0; m_sh_cm = 1'b0; m_act_cm = 1'b0;
    m_pend = 1'b0; m_tick = 1'b0; m_out = '0;
  endtask

  task automatic model_step();
    logic          tk, bnd, up_n;
    logic [W-1:0]  cn;
    logic [CH-1:0] out_n;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < CH; i++)
      out_n[i] = enable ? ((m_cnt < m_act_d[i*W +: W]) ^ m_act_pol[i]) : m_act_pol[i];
    if (!enable) begin
      m_pre = '0; m_cnt = '0; m_up = 1'b1; m_tick = 1'b0;
      m_act_p = m_sh_p; m_act_d = m_sh_d; m_act_pol = m_sh_pol; m_act_cm = m_sh_cm;
      m_pend = 1'b0;
    end else begin
      tk    = (m_pre >= prescale);
      m_pre = tk ? '0 : m_pre + 1'b1;
      up_n  = m_up;
      if (!m_act_cm) begin
        cn   = (m_cnt >= m_act_p) ? '0 : m_cnt + 1'b1;
        up_n = 1'b1;
      end else if (m_up && (m_cnt < m_act_p)) begin
        cn = m_cnt + 1'b1;
      end else if (m_act_p == '0) begin
        cn = '0;
      end else begin
        cn   = m_cnt - 1'b1;
        up_n = (cn == '0);
      end
      bnd    = tk && (cn == '0);
      m_tick = bnd;
      if (tk) begin
        m_cnt = cn;
        m_up  = up_n;
      end
      if (bnd && m_pend) begin
        m_act_p = m_sh_p; m_act_d = m_sh_d; m_act_pol = m_sh_pol; m_act_cm = m_sh_cm;
      end
      if (bus.update) m_pend = 1'b1;
      else if (bnd)   m_pend = 1'b0;
    end
    if (bus.update) begin
      m_sh_p = bus.period; m_sh_d = bus.duty; m_sh_pol = bus.polarity; m_sh_cm = bus.center_mode;
    end
    m_out = out_n;
  endtask

  // One clock: predict, enqueue, advance, then pop and compare away from the edge.
  task automatic cycle();
    exp_t e;
    model_step();
    sbq.push_back('{out: m_out, tick: m_tick, pend: m_pend});
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    n_cmp++;
    if (pwm_out !== e.out) begin
      n_bad++;
      $display("FAIL sb_pwm_out t=%0t got %b exp %b", $time, pwm_out, e.out);
    end
    n_cmp++;
    if (period_tick !== e.tick) begin
      n_bad++;
      $display("FAIL sb_period_tick t=%0t got %b exp %b", $time, period_tick, e.tick);
    end
    n_cmp++;
    if (bus.update_pending !== e.pend) begin
      n_bad++;
      $display("FAIL sb_update_pending t=%0t got %b exp %b", $time, bus.update_pending, e.pend);
    end
    for (int i = 0; i < CH; i++) if (pwm_out[i] === 1'b1) hi_cnt[i]++;
    if (period_tick === 1'b1) tick_cnt++;
  endtask

  task automatic clear_stats();
    for (int i = 0; i < CH; i++) hi_cnt[i] = 0;
    tick_cnt = 0;
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (period_tick !== 1'b1 && n < 200);
    if (period_tick !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_tick_timeout t=%0t got no period_tick within %0d clks", $time, n);
    end
  endtask

  task automatic run_until_cnt(input logic [W-1:0] v);
    int k = 0;
    while (m_cnt != v && k < 200) begin
      cycle();
      k++;
    end
    if (m_cnt != v) begin
      n_cmp++; n_bad++;
      $display("FAIL run_until_cnt_timeout got count %0d required %0d", m_cnt, v);
    end
  endtask

  task automatic load(input logic [W-1:0] p, input logic [CH*W-1:0] d,
                      input logic [CH-1:0] pol, input logic cm);
    bus.period = p; bus.duty = d; bus.polarity = pol; bus.center_mode = cm;
    bus.update = 1'b1;
    cycle();
    bus.update = 1'b0;
  endtask

  // Load while disabled so the values go active immediately, then start counting from 0.
  task automatic setup(input logic [W-1:0] p, input logic [CH*W-1:0] d,
                       input logic [CH-1:0] pol, input logic cm);
    enable = 1'b0;
    load(p, d, pol, cm);
    cycle();
    cycle();
    enable = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; prescale = '0;
    bus.period = '0; bus.duty = '0; bus.polarity = '0; bus.center_mode = 1'b0; bus.update = 1'b0;
    model_reset();
    #2;
    n_cmp++;
    if (pwm_out !== '0) begin n_bad++; $display("FAIL reset_pwm_out got %b exp 0", pwm_out); end
    n_cmp++;
    if (period_tick !== 1'b0) begin n_bad++; $display("FAIL reset_period_tick got %b exp 0", period_tick); end
    n_cmp++;
    if (bus.update_pending !== 1'b0) begin n_bad++; $display("FAIL reset_pending got %b exp 0", bus.update_pending); end
    cycle(); cycle();
    rst_n = 1'b1;
    cycle(); cycle();
  endtask

  task automatic test_edge();
    int n;
    setup(16'd9, {16'd10, 16'd5, 16'd0, 16'd3}, 4'b0000, 1'b0);
    repeat (10) cycle();
    clear_stats();
    repeat (40) cycle();
    n_cmp++;
    if (hi_cnt[0] != 12) begin n_bad++; $display("FAIL edge_d3_high got %0d exp 12", hi_cnt[0]); end
    n_cmp++;
    if (hi_cnt[1] != 0) begin n_bad++; $display("FAIL edge_d0_high got %0d exp 0", hi_cnt[1]); end
    n_cmp++;
    if (hi_cnt[2] != 20) begin n_bad++; $display("FAIL edge_d5_high got %0d exp 20", hi_cnt[2]); end
    n_cmp++;
    if (hi_cnt[3] != 40) begin n_bad++; $display("FAIL edge_d10_high got %0d exp 40", hi_cnt[3]); end
    n_cmp++;
    if (tick_cnt != 4) begin n_bad++; $display("FAIL edge_ticks got %0d exp 4", tick_cnt); end
    wait_tick(n);
    wait_tick(n);
    n_cmp++;
    if (n != 10) begin n_bad++; $display("FAIL edge_tick_spacing got %0d exp 10", n); end
  endtask

  task automatic test_center();
    int n;
    setup(16'd8, {4{16'd4}}, 4'b0000, 1'b1);
    repeat (16) cycle();
    clear_stats();
    repeat (64) cycle();
    n_cmp++;
    if (tick_cnt != 4) begin n_bad++; $display("FAIL center_ticks got %0d exp 4", tick_cnt); end
    // count < 4 holds for 0..3 rising and 3..1 falling: 7 of every 16 ticks.
    n_cmp++;
    if (hi_cnt[0] != 28) begin n_bad++; $display("FAIL center_high got %0d exp 28", hi_cnt[0]); end
    wait_tick(n);
    wait_tick(n);
    n_cmp++;
    if (n != 16) begin n_bad++; $display("FAIL center_tick_spacing got %0d exp 16", n); end
  endtask

  task automatic test_limits();
    setup(16'd5, {16'd3, 16'hFFFF, 16'd6, 16'd0}, 4'b0000, 1'b0);
    repeat (6) cycle();
    clear_stats();
    repeat (24) cycle();
    n_cmp++;
    if (hi_cnt[0] != 0) begin n_bad++; $display("FAIL lim_d0 got %0d exp 0", hi_cnt[0]); end
    n_cmp++;
    if (hi_cnt[1] != 24) begin n_bad++; $display("FAIL lim_d6 got %0d exp 24", hi_cnt[1]); end
    n_cmp++;
    if (hi_cnt[2] != 24) begin n_bad++; $display("FAIL lim_dffff got %0d exp 24", hi_cnt[2]); end
    n_cmp++;
    if (hi_cnt[3] != 12) begin n_bad++; $display("FAIL lim_d3 got %0d exp 12", hi_cnt[3]); end
    setup(16'd5, {16'd3, 16'hFFFF, 16'd6, 16'd0}, 4'b1111, 1'b0);
    repeat (6) cycle();
    clear_stats();
    repeat (24) cycle();
    n_cmp++;
    if (hi_cnt[0] != 24) begin n_bad++; $display("FAIL lim_inv_d0 got %0d exp 24", hi_cnt[0]); end
    n_cmp++;
    if (hi_cnt[1] != 0) begin n_bad++; $display("FAIL lim_inv_d6 got %0d exp 0", hi_cnt[1]); end
    n_cmp++;
    if (hi_cnt[2] != 0) begin n_bad++; $display("FAIL lim_inv_dffff got %0d exp 0", hi_cnt[2]); end
    n_cmp++;
    if (hi_cnt[3] != 12) begin n_bad++; $display("FAIL lim_inv_d3 got %0d exp 12", hi_cnt[3]); end
  endtask

  task automatic test_update_mid();
    int n;
    setup(16'd9, {48'd0, 16'd3}, 4'b0000, 1'b0);
    run_until_cnt(16'd5);
    load(16'd4, {48'd0, 16'd2}, 4'b0000, 1'b0);
    n_cmp++;
    if (bus.update_pending !== 1'b1) begin n_bad++; $display("FAIL upd_pending_set got %b exp 1", bus.update_pending); end
    wait_tick(n);
    n_cmp++;
    if (bus.update_pending !== 1'b0) begin n_bad++; $display("FAIL upd_pending_clear got %b exp 0", bus.update_pending); end
    clear_stats();
    wait_tick(n);
    n_cmp++;
    if (n != 5) begin n_bad++; $display("FAIL upd_new_period got %0d exp 5", n); end
    n_cmp++;
    if (hi_cnt[0] != 2) begin n_bad++; $display("FAIL upd_new_duty got %0d exp 2", hi_cnt[0]); end
    // Strobe exactly on the next boundary edge: must wait one more period to apply.
    repeat (4) cycle();
    load(16'd7, {48'd0, 16'd5}, 4'b0000, 1'b0);
    n_cmp++;
    if (bus.update_pending !== 1'b1) begin n_bad++; $display("FAIL upd_bnd_pending got %b exp 1", bus.update_pending); end
    wait_tick(n);
    n_cmp++;
    if (n != 5) begin n_bad++; $display("FAIL upd_bnd_old_period got %0d exp 5", n); end
    wait_tick(n);
    n_cmp++;
    if (n != 8) begin n_bad++; $display("FAIL upd_bnd_new_period got %0d exp 8", n); end
  endtask

  task automatic test_prescale();
    int n;
    enable = 1'b0;
    prescale = 8'd3;
    setup(16'd3, {48'd0, 16'd2}, 4'b0000, 1'b0);
    wait_tick(n);
    wait_tick(n);
    n_cmp++;
    if (n != 16) begin n_bad++; $display("FAIL presc_tick_spacing got %0d exp 16", n); end
    enable = 1'b0;
    prescale = '0;
    cycle();
  endtask

  task automatic test_enable_drop();
    setup(16'd9, {4{16'd10}}, 4'b0101, 1'b0);
    run_until_cnt(16'd6);
    enable = 1'b0;
    cycle();
    n_cmp++;
    if (pwm_out !== 4'b0101) begin n_bad++; $display("FAIL en_drop_inactive got %b exp 0101", pwm_out); end
    n_cmp++;
    if (period_tick !== 1'b0) begin n_bad++; $display("FAIL en_drop_tick got %b exp 0", period_tick); end
    repeat (3) cycle();
    enable = 1'b1;
    repeat (12) cycle();
  endtask

  task automatic test_reset_mid();
    load(16'd9, {48'd0, 16'd3}, 4'b0000, 1'b0);
    repeat (3) cycle();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (pwm_out !== '0) begin n_bad++; $display("FAIL rst_mid_pwm_out got %b exp 0", pwm_out); end
    n_cmp++;
    if (bus.update_pending !== 1'b0) begin n_bad++; $display("FAIL rst_mid_pending got %b exp 0", bus.update_pending); end
    model_reset();
    cycle(); cycle();
    rst_n = 1'b1;
    load(16'd9, {48'd0, 16'd3}, 4'b0000, 1'b0);
    repeat (25) cycle();
  endtask

  initial begin
    test_reset();
    test_edge();
    test_center();
    test_limits();
    test_update_mid();
    test_prescale();
    test_enable_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got no completion by t=%0t", $time);
    $fatal(1);
  end

endmodule
